spike_window_capture: RTL and testbench

Serial-to-parallel spike capture stage that sits directly upstream of the barrel shifter. It samples one spike line over a window of LEN clock cycles and builds a LEN-bit time-stamped vector, where bit t means "spike at t cycles after window start". It hands the finished vector, plus its popcount, to the shifter input over a valid/ready handshake. One completed window can be parked internally while the output is back-pressured.

---
 rtl/spike_window_capture.sv | 156 +++++++++++++++
 tb/tb_spike_window_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_window_capture.sv
// Serial-to-parallel spike capture: samples one spike line over a LEN-cycle window and hands
// the time-indexed vector plus its popcount downstream over valid/ready, parking one extra window.
module spike_window_capture #(
    parameter  int unsigned LEN    = 8,
    parameter  int unsigned THERMO = 0,
    localparam int unsigned CW     = $clog2(LEN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            spike_in,
    input  logic            win_start,
    input  logic            ovr_clr,
    output logic [0:LEN-1]  spike_vec,
    output logic [CW-1:0]   spike_cnt,
    output logic            vec_valid,
    input  logic            vec_ready,
    output logic            busy,
    output logic            overrun
);

    localparam int unsigned TW = $clog2(LEN);

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StFull
    } state_e;

    state_e          state_q, state_d;
    logic [0:LEN-1]  cap_q, cap_d;
    logic [TW-1:0]   t_q, t_d;
    logic [0:LEN-1]  vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            ovr_q, ovr_d;

    logic [0:LEN-1]  cap_smp;
    logic [0:LEN-1]  start_vec;
    logic            prev_bit;
    logic            last_sample;
    logic            slot_free;
    logic            handshake;

    function automatic logic [CW-1:0] popcount(input logic [0:LEN-1] v);
        logic [CW-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < LEN; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    // Capture register with the current cycle's sample folded in at position t.
    always_comb begin
        cap_smp  = cap_q;
        prev_bit = (t_q == '0) ? 1'b0 : cap_q[t_q - TW'(1)];
        if (THERMO != 0) begin
            cap_smp[t_q] = spike_in | prev_bit;
        end else begin
            cap_smp[t_q] = spike_in;
        end
    end

    always_comb begin
        start_vec    = '0;
        start_vec[0] = spike_in;
    end

    assign last_sample = (t_q == TW'(LEN - 1));
    assign handshake   = valid_q && vec_ready;
    assign slot_free   = !valid_q || vec_ready;

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        t_d     = t_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        valid_d = valid_q && !vec_ready;
        ovr_d   = ovr_q && !ovr_clr;

        // A request that cannot be accepted is dropped; setting beats clearing.
        if (win_start && (state_q != StIdle)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (win_start) begin
                    cap_d   = start_vec;
                    t_d     = TW'(1);
                    state_d = StCapture;
                end
            end
            StCapture: begin
                cap_d = cap_smp;
                if (last_sample) begin
                    t_d = '0;
                    if (slot_free) begin
                        vec_d   = cap_smp;
                        cnt_d   = popcount(cap_smp);
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StFull;
                    end
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            StFull: begin
                if (handshake) begin
                    vec_d   = cap_q;
                    cnt_d   = popcount(cap_q);
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cap_q   <= '0;
            t_q     <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            t_q     <= t_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign spike_vec = vec_q;
    assign spike_cnt = cnt_q;
    assign vec_valid = valid_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_spike_window_capture.sv
// Directed bench for spike_window_capture: raw and thermometer instances share stimulus,
// expected vectors are queued per window and compared on each handshake.
module tb_spike_window_capture;

    localparam int LEN = 8;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spike_in = 1'b0;
    logic win_start = 1'b0;
    logic ovr_clr = 1'b0;
    logic vec_ready = 1'b0;

    logic [0:LEN-1] vec_r, vec_t;
    logic [CW-1:0]  cnt_r, cnt_t;
    logic           vv_r, vv_t, busy_r, busy_t, ovr_r, ovr_t;

    int n_cmp = 0;
    int n_err = 0;

    logic [LEN+CW-1:0] q_raw[$];
    logic [LEN+CW-1:0] q_thm[$];
    logic [LEN+CW-1:0] e_r, e_t;

    always #5 clk = ~clk;

    spike_window_capture #(.LEN(LEN), .THERMO(0)) u_raw (
        .clk       (clk),
        .rst       (rst),
        .spike_in  (spike_in),
        .win_start (win_start),
        .ovr_clr   (ovr_clr),
        .spike_vec (vec_r),
        .spike_cnt (cnt_r),
        .vec_valid (vv_r),
        .vec_ready (vec_ready),
        .busy      (busy_r),
        .overrun   (ovr_r)
    );

    spike_window_capture #(.LEN(LEN), .THERMO(1)) u_thm (
        .clk       (clk),
        .rst       (rst),
        .spike_in  (spike_in),
        .win_start (win_start),
        .ovr_clr   (ovr_clr),
        .spike_vec (vec_t),
        .spike_cnt (cnt_t),
        .vec_valid (vv_t),
        .vec_ready (vec_ready),
        .busy      (busy_t),
        .overrun   (ovr_t)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vec_raw"}, 32'(vec_r), 0);
        chk({tag, "_cnt_raw"}, 32'(cnt_r), 0);
        chk({tag, "_vv_raw"}, 32'(vv_r), 0);
        chk({tag, "_busy_raw"}, 32'(busy_r), 0);
        chk({tag, "_ovr_raw"}, 32'(ovr_r), 0);
        chk({tag, "_vec_thm"}, 32'(vec_t), 0);
        chk({tag, "_cnt_thm"}, 32'(cnt_t), 0);
        chk({tag, "_vv_thm"}, 32'(vv_t), 0);
        chk({tag, "_busy_thm"}, 32'(busy_t), 0);
        chk({tag, "_ovr_thm"}, 32'(ovr_t), 0);
    endtask

    // Reference encodings: raw copy and thermometer from the first spike onward.
    task automatic push_exp(input logic [0:LEN-1] pat);
        logic [0:LEN-1] thm;
        logic           seen;
        int             nr, nt;
        seen = 1'b0;
        nr   = 0;
        nt   = 0;
        for (int i = 0; i < LEN; i++) begin
            seen   = seen | pat[i];
            thm[i] = seen;
            if (pat[i]) nr++;
            if (seen) nt++;
        end
        q_raw.push_back({pat, CW'(nr)});
        q_thm.push_back({thm, CW'(nt)});
    endtask

    // Opens a window now and drives LEN samples; returns at start + LEN.
    task automatic run_window(input logic [0:LEN-1] pat, input int ovr_at, input int clr_at);
        push_exp(pat);
        win_start = 1'b1;
        ovr_clr   = 1'b0;
        spike_in  = pat[0];
        step();
        for (int i = 1; i < LEN; i++) begin
            win_start = (i == ovr_at);
            ovr_clr   = (i == clr_at);
            spike_in  = pat[i];
            if (i == 1) begin
                chk("busy_raw", 32'(busy_r), 1);
                chk("busy_thm", 32'(busy_t), 1);
            end
            step();
        end
        win_start = 1'b0;
        ovr_clr   = 1'b0;
        spike_in  = 1'b0;
        chk("lat_valid_raw", 32'(vv_r), 1);
        chk("lat_valid_thm", 32'(vv_t), 1);
    endtask

    always @(negedge clk) begin
        if (!rst && vv_r && vec_ready) begin
            chk("raw_q_nonempty", 32'(q_raw.size() != 0), 1);
            if (q_raw.size() != 0) begin
                e_r = q_raw.pop_front();
                chk("raw_vec", 32'(vec_r), 32'(e_r[LEN+CW-1:CW]));
                chk("raw_cnt", 32'(cnt_r), 32'(e_r[CW-1:0]));
            end
        end
        if (!rst && vv_t && vec_ready) begin
            chk("thm_q_nonempty", 32'(q_thm.size() != 0), 1);
            if (q_thm.size() != 0) begin
                e_t = q_thm.pop_front();
                chk("thm_vec", 32'(vec_t), 32'(e_t[LEN+CW-1:CW]));
                chk("thm_cnt", 32'(cnt_t), 32'(e_t[CW-1:0]));
            end
        end
    end

    initial begin
        logic [0:LEN-1] pat_a, pat_b;
        pat_a = 8'b0110_0011;
        pat_b = 8'b1000_0001;

        step();
        step();
        chk_zero("reset");
        rst = 1'b0;
        step();

        // Raw / thermometer capture, single-cycle valid with ready held high
        vec_ready = 1'b1;
        run_window(8'b0100_0010, -1, -1);
        step();
        chk("one_cycle_valid", 32'(vv_r), 0);
        run_window(8'b0001_0000, -1, -1);

        // Boundaries, back-to-back with no gap
        run_window(8'b1000_0000, -1, -1);
        run_window(8'b1111_1111, -1, -1);
        run_window(8'b0000_0000, -1, -1);
        step();

        // Overrun during capture, clear, then set-wins
        run_window(8'b1100_1100, 3, -1);
        chk("ovr_set_raw", 32'(ovr_r), 1);
        chk("ovr_set_thm", 32'(ovr_t), 1);
        step();
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovr_clr", 32'(ovr_r), 0);
        run_window(8'b0011_0000, 2, 2);
        chk("ovr_set_wins", 32'(ovr_r), 1);
        step();
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovr_clr2", 32'(ovr_r), 0);

        // Back-pressure: A held, B parked
        vec_ready = 1'b0;
        run_window(pat_a, -1, -1);
        run_window(pat_b, -1, -1);
        chk("full_busy", 32'(busy_r), 1);
        chk("full_hold_a", 32'(vec_r), 32'(pat_a));
        win_start = 1'b1;
        step();
        win_start = 1'b0;
        chk("full_ovr", 32'(ovr_r), 1);
        chk("full_busy2", 32'(busy_r), 1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("full_ovr_clr", 32'(ovr_r), 0);
        vec_ready = 1'b1;
        win_start = 1'b1;
        step();
        win_start = 1'b0;
        chk("full_exit_ovr", 32'(ovr_r), 1);
        chk("full_exit_idle", 32'(busy_r), 0);
        chk("full_exit_valid", 32'(vv_r), 1);
        chk("full_exit_vec_b", 32'(vec_r), 32'(pat_b));
        step();
        chk("b_consumed", 32'(vv_r), 0);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;

        // Reset at window t=4 with an older vector still valid
        vec_ready = 1'b0;
        run_window(8'b0010_0100, -1, -1);
        win_start = 1'b1;
        spike_in  = 1'b1;
        step();
        win_start = 1'b0;
        for (int i = 1; i < 4; i++) step();
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        q_raw.delete();
        q_thm.delete();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        spike_in = 1'b0;
        step();
        vec_ready = 1'b1;
        run_window(8'b0000_0001, -1, -1);
        step();
        chk("post_rst_consumed", 32'(vv_r), 0);
        chk("hold_vec_after_consume", 32'(vec_r), 32'h01);
        chk("raw_q_drained", 32'(q_raw.size()), 0);
        chk("thm_q_drained", 32'(q_thm.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
